// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - branch condition codes, REGIMM opcode and condition decode.
package branch_resolve_pkg;

    localparam logic [5:0] EXE_REGIMM = 6'b000001;

    typedef enum logic [2:0] {
        COND_EQ  = 3'd0,
        COND_NE  = 3'd1,
        COND_LEZ = 3'd2,
        COND_GTZ = 3'd3,
        COND_LTZ = 3'd4,
        COND_GEZ = 3'd5
    } cond_t;

    // Branch-likely and link variants share the base opcode's low bits / rt[16] selector.
    function automatic cond_t decodeCond(input logic [5:0] op, input logic rtSel);
        cond_t c;
        c = COND_EQ;
        if (op == EXE_REGIMM) begin
            c = rtSel ? COND_GEZ : COND_LTZ;
        end else if (op[5:2] == 4'b0001 || op[5:2] == 4'b0101) begin
            case (op[1:0])
                2'b00:   c = COND_EQ;
                2'b01:   c = COND_NE;
                2'b10:   c = COND_LEZ;
                default: c = COND_GTZ;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch condition evaluation on Execute operands.
module branch_cond
    import branch_resolve_pkg::*;
(
    input  cond_t       cond,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        take
);

    logic rsZero;
    assign rsZero = (rs == 32'd0);

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ:  take = (rs == rt);
            COND_NE:  take = (rs != rt);
            COND_LEZ: take = rs[31] | rsZero;
            COND_GTZ: take = ~rs[31] & ~rsZero;
            COND_LTZ: take = rs[31];
            COND_GEZ: take = ~rs[31];
            default:  take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - D->E->M branch resolution, predictor update and mispredict redirect.
// Optional BRANCH_PERF_CNT_EN adds branch_cnt / mispred_cnt performance counters.
module branch_resolve
    import branch_resolve_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallE,
    input  logic        flushE,
    input  logic        stallM,
    input  logic        flushM,
    input  logic [31:0] instrD,
    input  logic [31:0] pcD,
    input  logic [31:0] immD,
    input  logic        branchD,
    input  logic        branchL_D,
    input  logic        pred_takeD,
    input  logic [31:0] rs_valueE,
    input  logic [31:0] rt_valueE,
    output logic [31:0] pcM,
    output logic        branchM,
    output logic        actual_takeM,
    output logic        mispredM,
    output logic [31:0] redirect_pcM,
    output logic        nullify_slotM
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
`endif
);

    logic        branchE;
    logic        branchLE;
    logic        predE;
    logic [31:0] pcE;
    logic [31:0] targetE;
    cond_t       condE;
    cond_t       condD;
    logic        takeE;
    logic        unusedInstrBits;

    assign condD           = decodeCond(instrD[31:26], instrD[16]);
    assign unusedInstrBits = ^{instrD[25:17], instrD[15:0], immD[31:30]};

    // Younger instructions behind a mispredicted branch are squashed even when E is stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branchE  <= 1'b0;
            branchLE <= 1'b0;
            predE    <= 1'b0;
            pcE      <= 32'd0;
            targetE  <= 32'd0;
            condE    <= COND_EQ;
        end else if (flushE || mispredM) begin
            branchE  <= 1'b0;
            branchLE <= 1'b0;
            predE    <= 1'b0;
        end else if (!stallE) begin
            branchE  <= branchD;
            branchLE <= branchL_D;
            predE    <= pred_takeD;
            pcE      <= pcD;
            targetE  <= pcD + 32'd4 + {immD[29:0], 2'b00};
            condE    <= condD;
        end
    end

    branch_cond uCond (
        .cond (condE),
        .rs   (rs_valueE),
        .rt   (rt_valueE),
        .take (takeE)
    );

    // A stalled M keeps the mispredict visible; the self-flush fires once the stall releases.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branchM       <= 1'b0;
            actual_takeM  <= 1'b0;
            mispredM      <= 1'b0;
            nullify_slotM <= 1'b0;
            pcM           <= 32'd0;
            redirect_pcM  <= 32'd0;
        end else if (flushM || (mispredM && !stallM)) begin
            branchM       <= 1'b0;
            actual_takeM  <= 1'b0;
            mispredM      <= 1'b0;
            nullify_slotM <= 1'b0;
        end else if (!stallM) begin
            branchM       <= branchE;
            actual_takeM  <= branchE & takeE;
            mispredM      <= branchE & (takeE ^ predE);
            nullify_slotM <= branchE & branchLE & ~takeE;
            pcM           <= pcE;
            redirect_pcM  <= takeE ? targetE : pcE + 32'd8;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else if (branchM && !stallM) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mispredM) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed-vector bench for branch_resolve.
module tb_branch_resolve;

    logic        clk;
    logic        resetn;
    logic        stallE, flushE, stallM, flushM;
    logic [31:0] instrD, pcD, immD;
    logic        branchD, branchL_D, pred_takeD;
    logic [31:0] rs_valueE, rt_valueE;
    logic [31:0] pcM, redirect_pcM;
    logic        branchM, actual_takeM, mispredM, nullify_slotM;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_cnt, mispred_cnt;
`endif

    int vecs = 0;
    int miss = 0;

    localparam logic [31:0] BEQ   = 32'h1000_0000;
    localparam logic [31:0] BNE   = 32'h1400_0000;
    localparam logic [31:0] BGTZ  = 32'h1C00_0000;
    localparam logic [31:0] BLEZL = 32'h5800_0000;
    localparam logic [31:0] BLTZ  = 32'h0400_0000;
    localparam logic [31:0] BGEZ  = 32'h0401_0000;
    localparam logic [31:0] BGEZAL = 32'h0411_0000;

    branch_resolve dut (
        .clk           (clk),
        .resetn        (resetn),
        .stallE        (stallE),
        .flushE        (flushE),
        .stallM        (stallM),
        .flushM        (flushM),
        .instrD        (instrD),
        .pcD           (pcD),
        .immD          (immD),
        .branchD       (branchD),
        .branchL_D     (branchL_D),
        .pred_takeD    (pred_takeD),
        .rs_valueE     (rs_valueE),
        .rt_valueE     (rt_valueE),
        .pcM           (pcM),
        .branchM       (branchM),
        .actual_takeM  (actual_takeM),
        .mispredM      (mispredM),
        .redirect_pcM  (redirect_pcM),
        .nullify_slotM (nullify_slotM)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setD(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                        input logic bl, input logic pr);
        instrD = instr; pcD = pc; immD = imm;
        branchD = 1'b1; branchL_D = bl; pred_takeD = pr;
    endtask

    task automatic clearD();
        instrD = 32'd0; branchD = 1'b0; branchL_D = 1'b0; pred_takeD = 1'b0;
    endtask

    // Branch into D, one edge into E with its operands, one edge into M.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                         input logic bl, input logic pr, input logic [31:0] rs, input logic [31:0] rt);
        setD(instr, pc, imm, bl, pr);
        tick();
        clearD();
        rs_valueE = rs; rt_valueE = rt;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        stallE = 0; flushE = 0; stallM = 0; flushM = 0;
        pcD = 0; immD = 0; rs_valueE = 0; rt_valueE = 0;
        clearD();
        tick();
        tick();
        vecs++; if (branchM !== 1'b0) begin miss++; $display("FAIL reset_branchM got=%0h exp=0", branchM); end
        vecs++; if (actual_takeM !== 1'b0) begin miss++; $display("FAIL reset_actual got=%0h exp=0", actual_takeM); end
        vecs++; if (mispredM !== 1'b0) begin miss++; $display("FAIL reset_mispred got=%0h exp=0", mispredM); end
        vecs++; if (nullify_slotM !== 1'b0) begin miss++; $display("FAIL reset_nullify got=%0h exp=0", nullify_slotM); end
        vecs++; if (pcM !== 32'd0) begin miss++; $display("FAIL reset_pcM got=%h exp=0", pcM); end
        vecs++; if (redirect_pcM !== 32'd0) begin miss++; $display("FAIL reset_redirect got=%h exp=0", redirect_pcM); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_beq_mispredict();
        setD(BEQ, 32'h1000, 32'd4, 1'b0, 1'b0);
        tick();
        setD(BEQ, 32'h1100, 32'd4, 1'b0, 1'b0);  // younger branch, must be squashed
        rs_valueE = 32'd5; rt_valueE = 32'd5;
        tick();
        clearD();
        vecs++; if (branchM !== 1'b1) begin miss++; $display("FAIL beq_branchM got=%0h exp=1", branchM); end
        vecs++; if (actual_takeM !== 1'b1) begin miss++; $display("FAIL beq_actual got=%0h exp=1", actual_takeM); end
        vecs++; if (mispredM !== 1'b1) begin miss++; $display("FAIL beq_mispred got=%0h exp=1", mispredM); end
        vecs++; if (redirect_pcM !== 32'h1014) begin miss++; $display("FAIL beq_redirect got=%h exp=00001014", redirect_pcM); end
        vecs++; if (pcM !== 32'h1000) begin miss++; $display("FAIL beq_pcM got=%h exp=00001000", pcM); end
        tick();
        vecs++; if (branchM !== 1'b0) begin miss++; $display("FAIL beq_bubbleM got=%0h exp=0", branchM); end
        vecs++; if (mispredM !== 1'b0) begin miss++; $display("FAIL beq_mispred_pulse got=%0h exp=0", mispredM); end
        tick();
        vecs++; if (branchM !== 1'b0) begin miss++; $display("FAIL beq_bubbleE got=%0h exp=0", branchM); end
    endtask

    task automatic test_bne_mispredict();
        issue(BNE, 32'h2000, 32'd16, 1'b0, 1'b1, 32'd7, 32'd7);
        vecs++; if (actual_takeM !== 1'b0) begin miss++; $display("FAIL bne_actual got=%0h exp=0", actual_takeM); end
        vecs++; if (mispredM !== 1'b1) begin miss++; $display("FAIL bne_mispred got=%0h exp=1", mispredM); end
        vecs++; if (redirect_pcM !== 32'h2008) begin miss++; $display("FAIL bne_redirect got=%h exp=00002008", redirect_pcM); end
        tick();
    endtask

    task automatic test_likely_nullify();
        issue(BLEZL, 32'h2400, 32'd3, 1'b1, 1'b0, 32'd1, 32'd0);
        vecs++; if (branchM !== 1'b1) begin miss++; $display("FAIL blezl_branchM got=%0h exp=1", branchM); end
        vecs++; if (actual_takeM !== 1'b0) begin miss++; $display("FAIL blezl_actual got=%0h exp=0", actual_takeM); end
        vecs++; if (mispredM !== 1'b0) begin miss++; $display("FAIL blezl_mispred got=%0h exp=0", mispredM); end
        vecs++; if (nullify_slotM !== 1'b1) begin miss++; $display("FAIL blezl_nullify got=%0h exp=1", nullify_slotM); end
        tick();
        vecs++; if (nullify_slotM !== 1'b0) begin miss++; $display("FAIL blezl_nullify_clear got=%0h exp=0", nullify_slotM); end
    endtask

    task automatic test_conditions();
        issue(BGEZ, 32'h3000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 32'd0);
        vecs++; if (actual_takeM !== 1'b0) begin miss++; $display("FAIL bgez_neg_actual got=%0h exp=0", actual_takeM); end
        vecs++; if (mispredM !== 1'b0) begin miss++; $display("FAIL bgez_neg_mispred got=%0h exp=0", mispredM); end
        vecs++; if (redirect_pcM !== 32'h3008) begin miss++; $display("FAIL bgez_neg_redirect got=%h exp=00003008", redirect_pcM); end
        tick();
        issue(BGEZ, 32'h3000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0);
        vecs++; if (actual_takeM !== 1'b1) begin miss++; $display("FAIL bgez_zero_actual got=%0h exp=1", actual_takeM); end
        vecs++; if (redirect_pcM !== 32'h3000) begin miss++; $display("FAIL bgez_zero_redirect got=%h exp=00003000", redirect_pcM); end
        tick();
        issue(BGTZ, 32'h3100, 32'd1, 1'b0, 1'b1, 32'd0, 32'd0);
        vecs++; if (actual_takeM !== 1'b0) begin miss++; $display("FAIL bgtz_zero_actual got=%0h exp=0", actual_takeM); end
        tick();
        issue(BGTZ, 32'h3100, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd0);
        vecs++; if (mispredM !== 1'b0) begin miss++; $display("FAIL bgtz_max_mispred got=%0h exp=0", mispredM); end
        vecs++; if (redirect_pcM !== 32'h3108) begin miss++; $display("FAIL bgtz_max_redirect got=%h exp=00003108", redirect_pcM); end
        tick();
        issue(BLTZ, 32'h3200, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0);
        vecs++; if (actual_takeM !== 1'b1) begin miss++; $display("FAIL bltz_actual got=%0h exp=1", actual_takeM); end
        tick();
        issue(BGEZAL, 32'h3300, 32'd2, 1'b0, 1'b0, 32'd5, 32'd0);
        vecs++; if (mispredM !== 1'b1) begin miss++; $display("FAIL bgezal_mispred got=%0h exp=1", mispredM); end
        tick();
    endtask

    task automatic test_wrap();
        issue(BEQ, 32'hFFFF_FFF0, 32'd4, 1'b0, 1'b1, 32'd9, 32'd9);
        vecs++; if (redirect_pcM !== 32'h0000_0004) begin miss++; $display("FAIL wrap_target got=%h exp=00000004", redirect_pcM); end
        vecs++; if (mispredM !== 1'b0) begin miss++; $display("FAIL wrap_mispred got=%0h exp=0", mispredM); end
        tick();
        issue(BNE, 32'hFFFF_FFFC, 32'd4, 1'b0, 1'b1, 32'd9, 32'd9);
        vecs++; if (redirect_pcM !== 32'h0000_0004) begin miss++; $display("FAIL wrap_pc8 got=%h exp=00000004", redirect_pcM); end
        tick();
    endtask

    task automatic test_back_to_back();
        setD(BEQ, 32'h4000, 32'd8, 1'b0, 1'b1);
        tick();
        setD(BNE, 32'h4004, 32'd8, 1'b0, 1'b0);
        rs_valueE = 32'd3; rt_valueE = 32'd3;
        tick();
        clearD();
        vecs++; if (actual_takeM !== 1'b1 || mispredM !== 1'b0) begin miss++; $display("FAIL b2b_first got=%0h/%0h exp=1/0", actual_takeM, mispredM); end
        vecs++; if (redirect_pcM !== 32'h4024) begin miss++; $display("FAIL b2b_first_redirect got=%h exp=00004024", redirect_pcM); end
        tick();
        vecs++; if (branchM !== 1'b1 || actual_takeM !== 1'b0) begin miss++; $display("FAIL b2b_second got=%0h/%0h exp=1/0", branchM, actual_takeM); end
        vecs++; if (redirect_pcM !== 32'h400C) begin miss++; $display("FAIL b2b_second_redirect got=%h exp=0000400c", redirect_pcM); end
        tick();
    endtask

    task automatic test_stall_flush();
        issue(BEQ, 32'h5000, 32'd1, 1'b0, 1'b0, 32'd2, 32'd2);
        vecs++; if (mispredM !== 1'b1) begin miss++; $display("FAIL stall_mispred_c0 got=%0h exp=1", mispredM); end
        stallM = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vecs++; if (mispredM !== 1'b1 || branchM !== 1'b1) begin miss++; $display("FAIL stall_hold_c%0d got=%0h/%0h exp=1/1", i, mispredM, branchM); end
        end
        stallM = 1'b0; flushM = 1'b1;
        tick();
        flushM = 1'b0;
        vecs++; if (branchM !== 1'b0 || mispredM !== 1'b0) begin miss++; $display("FAIL stall_release got=%0h/%0h exp=0/0", branchM, mispredM); end
        issue(BEQ, 32'h5100, 32'd1, 1'b0, 1'b1, 32'd2, 32'd2);
        stallM = 1'b1; flushM = 1'b1;
        tick();
        stallM = 1'b0; flushM = 1'b0;
        vecs++; if (branchM !== 1'b0) begin miss++; $display("FAIL flush_beats_stall got=%0h exp=0", branchM); end
        setD(BEQ, 32'h5200, 32'd1, 1'b0, 1'b1);
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        clearD();
        tick();
        vecs++; if (branchM !== 1'b0) begin miss++; $display("FAIL flushE_bubble got=%0h exp=0", branchM); end
        tick();
    endtask

    task automatic test_reset_midstream();
        issue(BEQ, 32'h6000, 32'd1, 1'b0, 1'b1, 32'd1, 32'd1);
        #2 resetn = 1'b0;
        #1;
        vecs++; if (branchM !== 1'b0 || actual_takeM !== 1'b0) begin miss++; $display("FAIL async_reset got=%0h/%0h exp=0/0", branchM, actual_takeM); end
        vecs++; if (redirect_pcM !== 32'd0) begin miss++; $display("FAIL async_reset_redirect got=%h exp=0", redirect_pcM); end
        resetn = 1'b1;
        issue(BNE, 32'h6100, 32'd1, 1'b0, 1'b0, 32'd1, 32'd2);
        vecs++; if (branchM !== 1'b1 || actual_takeM !== 1'b1) begin miss++; $display("FAIL post_reset_branch got=%0h/%0h exp=1/1", branchM, actual_takeM); end
        vecs++; if (redirect_pcM !== 32'h6108) begin miss++; $display("FAIL post_reset_redirect got=%h exp=00006108", redirect_pcM); end
        tick();
    endtask

`ifdef BRANCH_PERF_CNT_EN
    task automatic test_perf_counters();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(BEQ, 32'h7000 + 32'(i * 16), 32'd2, 1'b0, (i % 3 == 0 && i < 9) ? 1'b0 : 1'b1, 32'd4, 32'd4);
            tick();
        end
        vecs++; if (branch_cnt !== 32'd10) begin miss++; $display("FAIL branch_cnt got=%0d exp=10", branch_cnt); end
        vecs++; if (mispred_cnt !== 32'd3) begin miss++; $display("FAIL mispred_cnt got=%0d exp=3", mispred_cnt); end
        #2 resetn = 1'b0;
        #1;
        vecs++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin miss++; $display("FAIL cnt_async_reset got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt); end
        resetn = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_beq_mispredict();
        test_bne_mispredict();
        test_likely_nullify();
        test_conditions();
        test_wrap();
        test_back_to_back();
        test_stall_flush();
        test_reset_midstream();
`ifdef BRANCH_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Resolves conditional branches predicted by the front-end two-level predictor. Captures each branch's decode-stage prediction, evaluates the real condition in Execute and registers the outcome into Memory. In Memory it drives the predictor's update port (pcM, branchM, actual_takeM), plus a single-cycle flush/redirect when the prediction was wrong. Sits between decode, the execute forwarding network and the PC-select logic.

## Interface
- Parameters: none; all widths are fixed at 32-bit MIPS32.
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- stallE / flushE  in  1/1  Execute-stage stall and flush, from the hazard unit
- stallM / flushM  in  1/1  Memory-stage stall and flush, from the hazard unit
- instrD  in  32  decode-stage instruction
- pcD  in  32  decode-stage PC
- immD  in  32  sign-extended 16-bit offset
- branchD / branchL_D / pred_takeD  in  1/1/1  branch, branch-likely and predicted-taken flags from the predictor
- rs_valueE / rt_valueE  in  32/32  forwarded operands in Execute
- pcM  out  32  PC of the branch in Memory; reset 0
- branchM  out  1  a valid branch is in Memory; reset 0
- actual_takeM  out  1  resolved direction; reset 0
- mispredM  out  1  direction mispredicted; reset 0
- redirect_pcM  out  32  correct next fetch PC; reset 0
- nullify_slotM  out  1  a not-taken branch-likely whose delay slot must be squashed; reset 0

## Operation
- D→E register: when ~stallE, capture {branchD, branchL_D, pred_takeD, pcD, target = pcD+4+(immD<<2), cond}.
- cond encoding:
  - op[5:2]=0001 or 0101 → op[1:0]: 00 EQ, 01 NE, 10 LEZ, 11 GTZ.
  - op=`EXE_REGIMM → rt[16]: 0 LTZ, 1 GEZ.
  - The AL and L variants use the same conditions.
- Execute evaluates take_E from rs_valueE/rt_valueE using signed compares against zero. Target addition wraps modulo 2^32.
- E→M register: when ~stallM, capture take_E, pred, branchL, pc and target.
- In Memory, outputs are registered or derived from the M register:
  - mispredM = branchM & (actual_takeM ^ predM).
  - redirect_pcM = actual_takeM ? targetM : pcM+8.
  - nullify_slotM = branchM & branchL_M & ~actual_takeM.
- Self-flush: while mispredM=1, the next edge loads a bubble (all flags 0) into both E and M, regardless of stallE. The instructions in those stages are younger than the mispredicted branch.
- A non-branch or bubble in E moves into M with branchM=0. PC and target fields hold their last value and are don't-care.

## Timing
- Prediction in D → outcome on branchM/actual_takeM exactly 2 enabled edges later. mispredM is valid in the same cycle.
- mispredM is high for exactly 1 cycle per mispredicted branch, unless stallM holds the M register. While stalled, it stays high and the self-flush waits for the stall to release.
- Priority at each register: resetn low > flush (external, or self-flush from mispredM) > stall > load.
- flushM & stallM together: flush wins and M becomes a bubble.
- Reset deasserted mid-stream: all flags 0. The first branch resolves 2 edges after its capture.

## Configuration
- BRANCH_PERF_CNT_EN defined: adds the output ports branch_cnt[31:0] and mispred_cnt[31:0].
  - branch_cnt increments once per branch leaving M (branchM & ~stallM).
  - mispred_cnt increments once per such branch with mispredM=1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Condition codes (EQ/NE/LEZ/GTZ/LTZ/GEZ, 3-bit) go in defines.vh beside `EXE_REGIMM.
- One combinational sub-module, branch_cond: (cond, rs, rt) → take.

## Test plan
- BEQ at pcD=0x1000, immD=4, rs=rt=5, pred=0 → 2 cycles later branchM=1, actual_takeM=1, mispredM=1, redirect_pcM=0x1014, with E/M bubbled on the next edge.
- BNE at 0x2000 with pred=1, rs=rt → mispredM=1, redirect_pcM=0x2008.
- BLEZL with rs=1, pred=0 → actual_takeM=0, mispredM=0, nullify_slotM=1.
- BGEZ with rs=0x80000000 and pred=0 → actual_takeM=0, no mispredict. Same branch with rs=0 → taken.
- Mispredict held with stallM=1 for 3 cycles → mispredM stays high for 4 cycles. Then flushM=1 → next cycle branchM=0.
- With BRANCH_PERF_CNT_EN: 10 branches, 3 mispredicted → branch_cnt=10, mispred_cnt=3. Pulse resetn low → both 0 immediately (asynchronous).
